// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering execute results that lost the write port.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  wb_req_t i_req,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_req;
  end

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates load and execute results onto the register-file write port and
// tracks per-register pending writes for issue-stage hazard stalls.
module writeback_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            q_stall
);

  import riscv_pkg::*;

  wb_req_t               w_ex_req;
  wb_req_t               w_fifo_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_ld_sel;
  logic                  w_ex_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_we;
  logic [4:0]            w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic [NUM_REGS-1:0]   w_pending_d;

  logic                  r_wb_we;
  logic [4:0]            r_wb_rd;
  logic [XLEN-1:0]       r_wb_data;
  logic [NUM_REGS-1:0]   r_pending;

  assign w_ex_req.rd   = ex_rd;
  assign w_ex_req.data = ex_data;

  assign ex_ready = !w_fifo_full;
  assign w_ld_sel = ld_valid && (ld_rd != 5'd0);
  // x0 results are accepted but vanish here, so they never reach the FIFO.
  assign w_ex_acc = ex_valid && ex_ready && (ex_rd != 5'd0);
  assign w_pop    = !w_ld_sel && !w_fifo_empty;
  assign w_push   = w_ex_acc && (w_ld_sel || !w_fifo_empty);

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_rd   = r_wb_rd;
    w_sel_data = r_wb_data;
    if (w_ld_sel) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = ld_rd;
      w_sel_data = ld_data;
    end else if (!w_fifo_empty) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = w_fifo_head.rd;
      w_sel_data = w_fifo_head.data;
    end else if (w_ex_acc) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = ex_rd;
      w_sel_data = ex_data;
    end
  end

  // Clear first so a same-cycle set on the retiring register wins.
  always_comb begin
    w_pending_d = r_pending;
    if (r_wb_we) w_pending_d[r_wb_rd] = 1'b0;
    if (sb_set)  w_pending_d[sb_rd]   = 1'b1;
    w_pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_pending <= '0;
    end else begin
      r_wb_we   <= w_sel_we;
      r_wb_rd   <= w_sel_rd;
      r_wb_data <= w_sel_data;
      r_pending <= w_pending_d;
    end
  end

  assign wb_we   = r_wb_we;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;
  assign q_stall = r_pending[q_rs1] || r_pending[q_rs2] || r_pending[q_rd];

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_req   (w_ex_req),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and random checks of writeback_unit against a queue-based model.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sb_set;
  logic [4:0]  sb_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        q_stall;

  always #5 clk = ~clk;

  writeback_unit #(
    .FIFO_DEPTH (DEPTH),
    .XLEN       (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_rd    (ex_rd),
    .ex_data  (ex_data),
    .ex_ready (ex_ready),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_rd     (q_rd),
    .q_stall  (q_stall)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } req_t;

  // Reference state: pending execute results in acceptance order, the
  // expected write-port registers, and the pending set.
  req_t        m_q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_pend[32];

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step();
    bit   accepted;
    req_t r;
    if (rst) begin
      model_reset();
      return;
    end
    accepted = ex_valid && (m_q.size() < DEPTH) && (ex_rd != 0);
    if (m_we) m_pend[m_rd] = 1'b0;
    if (sb_set && sb_rd != 0) m_pend[sb_rd] = 1'b1;
    r.rd   = ex_rd;
    r.data = ex_data;
    if (ld_valid && ld_rd != 0) begin
      m_we = 1'b1; m_rd = ld_rd; m_data = ld_data;
      if (accepted) m_q.push_back(r);
    end else if (m_q.size() > 0) begin
      r = m_q.pop_front();
      m_we = 1'b1; m_rd = r.rd; m_data = r.data;
      if (accepted) begin
        r.rd = ex_rd; r.data = ex_data;
        m_q.push_back(r);
      end
    end else if (accepted) begin
      m_we = 1'b1; m_rd = ex_rd; m_data = ex_data;
    end else begin
      m_we = 1'b0;
    end
  endtask

  // Inputs are already driven; check combinational outputs, advance one edge,
  // then check the registered write port.
  task automatic tick();
    #1;
    chk("ex_ready", ex_ready, (m_q.size() < DEPTH));
    chk("q_stall", q_stall, m_pend[q_rs1] | m_pend[q_rs2] | m_pend[q_rd]);
    if (ex_valid && ex_ready && !rst) acc_cnt++;
    model_step();
    @(posedge clk);
    #1;
    chk("wb_we", wb_we, m_we);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
  endtask

  task automatic idle();
    rst = 0; ex_valid = 0; ex_rd = 0; ex_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    sb_set = 0; sb_rd = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    // Reset state, then single-cycle execute bypass.
    tick();
    chk("reset_ex_ready", ex_ready, 1'b1);
    ex_valid = 1; ex_rd = 5; ex_data = 32'h11;
    tick();
    chk("bypass_we", wb_we, 1'b1);
    chk("bypass_rd", wb_rd, 5'd5);
    chk("bypass_data", wb_data, 32'h11);
    chk("bypass_ready", ex_ready, 1'b1);
    idle();

    // Load/execute collision: load first, execute next cycle.
    ld_valid = 1; ld_rd = 3; ld_data = 32'hAA;
    ex_valid = 1; ex_rd = 4; ex_data = 32'hBB;
    tick();
    chk("coll_ld_rd", wb_rd, 5'd3);
    chk("coll_ld_data", wb_data, 32'hAA);
    idle();
    tick();
    chk("coll_ex_rd", wb_rd, 5'd4);
    chk("coll_ex_data", wb_data, 32'hBB);
    tick();
    chk("coll_idle_we", wb_we, 1'b0);

    // Sustained loads fill the FIFO, then it drains in order.
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'hD000 + i;
      ex_valid = 1; ex_rd = 5'(8 + acc_cnt); ex_data = 32'hE000 + acc_cnt;
      tick();
    end
    chk("fill_accepted", acc_cnt, 4);
    #1;
    chk("fill_ready_low", ex_ready, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("drain_ready", ex_ready, 1'b1);

    // Scoreboard RAW stall and set-wins-over-clear.
    sb_set = 1; sb_rd = 7;
    tick();
    idle();
    q_rs1 = 7;
    tick();
    chk("sb_stall", q_stall, 1'b1);
    ex_valid = 1; ex_rd = 7; ex_data = 32'h77;
    tick();
    ex_valid = 0;
    sb_set = 1; sb_rd = 7;
    tick();
    sb_set = 0;
    #1;
    chk("sb_set_wins", q_stall, 1'b1);
    ex_valid = 1; ex_rd = 7; ex_data = 32'h78;
    tick();
    ex_valid = 0;
    tick();
    chk("sb_cleared", q_stall, 1'b0);

    // x0 writes are dropped everywhere.
    idle();
    ex_valid = 1; ld_valid = 1; sb_set = 1; ex_data = 32'h5; ld_data = 32'h6;
    tick();
    idle();
    tick();
    chk("x0_stall", q_stall, 1'b0);
    chk("x0_we", wb_we, 1'b0);

    // Reset with three buffered entries and pending bits.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(1 + i); ld_data = 32'hF0 + i;
      ex_valid = (i < 3); ex_rd = 5'(12 + i); ex_data = 32'hC0 + i;
      sb_set = 1; sb_rd = 5'(12 + i);
      tick();
    end
    idle();
    rst = 1; ld_valid = 1; ld_rd = 9; q_rs1 = 12; q_rs2 = 13;
    tick();
    idle();
    q_rs1 = 12; q_rs2 = 13; q_rd = 14;
    #1;
    chk("rst_ready", ex_ready, 1'b1);
    chk("rst_stall", q_stall, 1'b0);
    chk("rst_we", wb_we, 1'b0);
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      ex_valid = ($urandom_range(0, 9) < 6);
      ex_rd    = 5'($urandom_range(0, 31));
      ex_data  = $urandom;
      ld_valid = ($urandom_range(0, 9) < 4);
      ld_rd    = 5'($urandom_range(0, 31));
      ld_data  = $urandom;
      sb_set   = ($urandom_range(0, 3) == 0);
      sb_rd    = 5'($urandom_range(0, 31));
      q_rs1    = 5'($urandom_range(0, 31));
      q_rs2    = 5'($urandom_range(0, 31));
      q_rd     = 5'($urandom_range(0, 31));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
